// File: rtl/move_sequencer.sv
// Move sequencer: the single controller for the 4x4 node array.
// It accepts a move command and seeds the ready wave into the wall-side
// nodes, then collects per-lane completion from the far-end nodes.
// After each move it spawns a tile through the preset path. It also
// tallies merge pulses and detects game over.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a move command (move_ready_o high)
// S_LAUNCH | ready_seed_o drives the latched direction for one cycle
// S_WAIT   | collecting lane_end_i until all four lanes report or timeout
// S_SPAWN  | pick an empty cell from the LFSR start point, issue preset
// S_SETTLE | let the preset land on cell_values_i
// S_CHECK  | game-over test on cell_movable_i
// S_OVER   | terminal, only rst_i leaves
module move_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter logic [3:0]  FOUR_THRESH    = 4'd1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        move_valid_i,
   input  logic [3:0]  move_dir_i,
   output logic        move_ready_o,
   output logic [3:0]  ready_seed_o,
   input  logic [3:0]  lane_end_i,
   input  logic [63:0] cell_values_i,
   input  logic [31:0] cell_movable_i,
   input  logic [15:0] node_score_i,
   output logic        preset_ext_o,
   output logic [3:0]  preset_index_o,
   output logic [3:0]  preset_value_o,
   output logic [15:0] merge_count_o,
   output logic        busy_o,
   output logic        game_over_o,
   output logic        timeout_err_o
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_SPAWN,
      S_SETTLE,
      S_CHECK,
      S_OVER
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    dir_q, dir_d;
   logic [63:0]   snap_q, snap_d;
   logic [3:0]    lane_done_q, lane_done_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    init_left_q, init_left_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          preset_ext_q, preset_ext_d;
   logic [3:0]    preset_index_q, preset_index_d;
   logic [3:0]    preset_value_q, preset_value_d;
   logic [15:0]   merge_q, merge_d;
   logic          game_over_q, game_over_d;
   logic          timeout_q, timeout_d;

   logic          dir_onehot;
   logic [3:0]    lane_all;
   logic          hit;
   logic [3:0]    hit_idx;
   logic [3:0]    scan_idx;
   logic [4:0]    score_pop;
   logic [16:0]   merge_sum;

   assign dir_onehot = (move_dir_i != 4'd0) &&
                       ((move_dir_i & (move_dir_i - 4'd1)) == 4'd0);
   assign lane_all   = lane_done_q | lane_end_i;

   // First empty cell found by walking upward (mod 16) from the LFSR low nibble.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 4'd0;
      scan_idx = 4'd0;
      for (int k = 0; k < 16; k++) begin
         scan_idx = lfsr_q[3:0] + 4'(k);
         if (!hit && (cell_values_i[{scan_idx, 2'b00} +: 4] == 4'd0)) begin
            hit     = 1'b1;
            hit_idx = scan_idx;
         end
      end
   end

   // Free-running LFSR and saturating merge tally, active in every state.
   always_comb begin
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      score_pop = 5'd0;
      for (int b = 0; b < 16; b++) begin
         score_pop = score_pop + {4'd0, node_score_i[b]};
      end
      merge_sum = {1'b0, merge_q} + {12'd0, score_pop};
      merge_d   = merge_sum[16] ? 16'hFFFF : merge_sum[15:0];
   end

   // Next-state and datapath updates for the sequencing FSM.
   always_comb begin
      state_d        = state_q;
      dir_d          = dir_q;
      snap_d         = snap_q;
      lane_done_d    = lane_done_q;
      timer_d        = timer_q;
      init_left_d    = init_left_q;
      preset_ext_d   = 1'b0;
      preset_index_d = 4'd0;
      preset_value_d = 4'd0;
      game_over_d    = game_over_q;
      timeout_d      = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (move_valid_i && dir_onehot) begin
               dir_d       = move_dir_i;
               snap_d      = cell_values_i;
               lane_done_d = 4'd0;
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            timer_d = TIMER_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            lane_done_d = lane_all;
            if (lane_all == 4'hF) begin
               state_d = S_SPAWN;
            end else if (timer_q == '0) begin
               timeout_d = 1'b1;
               state_d   = S_SPAWN;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_SPAWN: begin
            // A move that changed nothing earns no new tile.
            if (!((init_left_q == 2'd0) && (cell_values_i == snap_q)) && hit) begin
               preset_ext_d   = 1'b1;
               preset_index_d = hit_idx;
               preset_value_d = (lfsr_q[7:4] < FOUR_THRESH) ? 4'd2 : 4'd1;
            end
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (init_left_q != 2'd0) begin
               init_left_d = init_left_q - 2'd1;
               state_d     = (init_left_q == 2'd1) ? S_IDLE : S_SPAWN;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cell_movable_i == 32'd0) begin
               game_over_d = 1'b1;
               state_d     = S_OVER;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_OVER: state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset restarts the initial two-tile spawn.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_SPAWN;
         dir_q          <= 4'd0;
         snap_q         <= 64'd0;
         lane_done_q    <= 4'd0;
         timer_q        <= '0;
         init_left_q    <= 2'd2;
         lfsr_q         <= LFSR_SEED;
         preset_ext_q   <= 1'b0;
         preset_index_q <= 4'd0;
         preset_value_q <= 4'd0;
         merge_q        <= 16'd0;
         game_over_q    <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         dir_q          <= dir_d;
         snap_q         <= snap_d;
         lane_done_q    <= lane_done_d;
         timer_q        <= timer_d;
         init_left_q    <= init_left_d;
         lfsr_q         <= lfsr_d;
         preset_ext_q   <= preset_ext_d;
         preset_index_q <= preset_index_d;
         preset_value_q <= preset_value_d;
         merge_q        <= merge_d;
         game_over_q    <= game_over_d;
         timeout_q      <= timeout_d;
      end
   end

   assign move_ready_o   = (state_q == S_IDLE);
   assign ready_seed_o   = (state_q == S_LAUNCH) ? dir_q : 4'd0;
   assign busy_o         = (state_q != S_IDLE) && (state_q != S_OVER);
   assign preset_ext_o   = preset_ext_q;
   assign preset_index_o = preset_index_q;
   assign preset_value_o = preset_value_q;
   assign merge_count_o  = merge_q;
   assign game_over_o    = game_over_q;
   assign timeout_err_o  = timeout_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: the bench plays the node array (board contents,
// lane completions, score pulses) and predicts every observable from the
// protocol rules: tile placement, handshake timing, timeout, game over,
// merge tally.
module tb_move_sequencer;

   localparam int          TIMEOUT = 64;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam logic [3:0]  THRESH  = 4'd1;
   localparam int          NEVER   = 1000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        move_valid_i;
   logic [3:0]  move_dir_i;
   logic        move_ready_o;
   logic [3:0]  ready_seed_o;
   logic [3:0]  lane_end_i;
   logic [63:0] cell_values_i;
   logic [31:0] cell_movable_i;
   logic [15:0] node_score_i;
   logic        preset_ext_o;
   logic [3:0]  preset_index_o;
   logic [3:0]  preset_value_o;
   logic [15:0] merge_count_o;
   logic        busy_o;
   logic        game_over_o;
   logic        timeout_err_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] board;
   logic [63:0] snap;
   logic [15:0] m_lfsr;
   logic [15:0] m_merge;
   bit          m_timeout;
   bit          score_en;

   always #5 clk_i = ~clk_i;

   assign cell_values_i = board;

   move_sequencer #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .LFSR_SEED      (SEED),
      .FOUR_THRESH    (THRESH)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .move_valid_i   (move_valid_i),
      .move_dir_i     (move_dir_i),
      .move_ready_o   (move_ready_o),
      .ready_seed_o   (ready_seed_o),
      .lane_end_i     (lane_end_i),
      .cell_values_i  (cell_values_i),
      .cell_movable_i (cell_movable_i),
      .node_score_i   (node_score_i),
      .preset_ext_o   (preset_ext_o),
      .preset_index_o (preset_index_o),
      .preset_value_o (preset_value_o),
      .merge_count_o  (merge_count_o),
      .busy_o         (busy_o),
      .game_over_o    (game_over_o),
      .timeout_err_o  (timeout_err_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Galois LFSR for x^16+x^14+x^13+x^11, shifting right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   function automatic int popcnt16(input logic [15:0] v);
      int c = 0;
      for (int b = 0; b < 16; b++) c += int'(v[b]);
      return c;
   endfunction

   function automatic logic [63:0] rand_board();
      logic [63:0] b;
      bit          full;
      full = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 16; i++)
         b[4*i +: 4] = full ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 3));
      return b;
   endfunction

   // One clock: advance the models, let the board absorb a preset strobe
   // the way the nodes would, then check the merge tally.
   task automatic tick();
      logic        pe;
      logic [3:0]  pi;
      logic [3:0]  pv;
      logic [15:0] sc;
      logic        r;
      int          s;
      pe = preset_ext_o;
      pi = preset_index_o;
      pv = preset_value_o;
      sc = node_score_i;
      r  = rst_i;
      @(posedge clk_i);
      #1;
      if (r) begin
         m_lfsr  = SEED;
         m_merge = 16'd0;
      end else begin
         m_lfsr  = lfsr_step(m_lfsr);
         s       = int'(m_merge) + popcnt16(sc);
         m_merge = (s > 65535) ? 16'hFFFF : 16'(s);
         if (pe) board[{pi, 2'b00} +: 4] = pv;
      end
      if (score_en) node_score_i = 16'($urandom & $urandom & $urandom);
      check_eq("merge_count", merge_count_o, m_merge);
   endtask

   // Called while the DUT sits in SPAWN; ends one cycle later in SETTLE.
   task automatic spawn_step(input bit init_phase, output logic [3:0] got_idx, output bit got_pe);
      bit         e_pe;
      logic [3:0] e_i;
      logic [3:0] e_v;
      logic [3:0] c;
      e_pe = 1'b0;
      e_i  = 4'd0;
      e_v  = 4'd0;
      if (init_phase || (board != snap)) begin
         for (int k = 0; k < 16; k++) begin
            c = 4'((int'(m_lfsr[3:0]) + k) % 16);
            if (!e_pe && board[{c, 2'b00} +: 4] == 4'd0) begin
               e_pe = 1'b1;
               e_i  = c;
               e_v  = (m_lfsr[7:4] < THRESH) ? 4'd2 : 4'd1;
            end
         end
      end
      check_eq("busy_spawn", busy_o, 1'b1);
      tick();
      check_eq("preset_ext", preset_ext_o, e_pe);
      check_eq("preset_index", preset_index_o, e_i);
      check_eq("preset_value", preset_value_o, e_v);
      check_eq("busy_settle", busy_o, 1'b1);
      got_idx = preset_index_o;
      got_pe  = preset_ext_o;
   endtask

   task automatic reset_and_spawn();
      logic [3:0] i1;
      logic [3:0] i2;
      bit         p1;
      bit         p2;
      rst_i        = 1'b1;
      move_valid_i = 1'b0;
      lane_end_i   = 4'd0;
      tick();
      rst_i = 1'b0;
      check_eq("rst_preset_ext", preset_ext_o, 1'b0);
      check_eq("rst_ready_seed", ready_seed_o, 4'd0);
      check_eq("rst_move_ready", move_ready_o, 1'b0);
      check_eq("rst_game_over", game_over_o, 1'b0);
      check_eq("rst_timeout", timeout_err_o, 1'b0);
      check_eq("rst_merge", merge_count_o, 16'd0);
      m_timeout = 1'b0;
      spawn_step(1'b1, i1, p1);
      tick();
      spawn_step(1'b1, i2, p2);
      tick();
      if (p1 && p2) check_eq("spawn_distinct", (i1 != i2), 1'b1);
      check_eq("init_move_ready", move_ready_o, 1'b1);
      check_eq("init_busy", busy_o, 1'b0);
   endtask

   // Full move from IDLE back to IDLE/OVER. Lane arrival times are WAIT
   // cycle indices (0 = first WAIT cycle); hold keeps a lane high once it
   // has arrived.
   task automatic do_move(input logic [3:0] dir, input int t0, input int t1, input int t2,
                          input int t3, input bit hold, input bit change,
                          input logic [63:0] nb, input logic [31:0] movable,
                          input logic [3:0] noise);
      int         t[4];
      int         maxt;
      int         jc;
      bit         tmo;
      logic [3:0] d;
      logic [3:0] gi;
      bit         gp;
      t    = '{t0, t1, t2, t3};
      maxt = 0;
      for (int l = 0; l < 4; l++) if (t[l] > maxt) maxt = t[l];
      tmo = (maxt > TIMEOUT - 1);
      jc  = tmo ? TIMEOUT - 1 : maxt;
      check_eq("idle_ready", move_ready_o, 1'b1);
      check_eq("idle_busy", busy_o, 1'b0);
      snap         = board;
      move_valid_i = 1'b1;
      move_dir_i   = dir;
      tick();
      move_valid_i = 1'b0;
      move_dir_i   = 4'd0;
      check_eq("launch_seed", ready_seed_o, dir);
      check_eq("launch_busy", busy_o, 1'b1);
      check_eq("launch_ready", move_ready_o, 1'b0);
      lane_end_i = noise;
      tick();
      lane_end_i = 4'd0;
      if (change) board = nb;
      for (int j = 0; j <= jc; j++) begin
         d = 4'd0;
         for (int l = 0; l < 4; l++) if (hold ? (j >= t[l]) : (j == t[l])) d[l] = 1'b1;
         lane_end_i = d;
         check_eq("wait_seed", ready_seed_o, 4'd0);
         check_eq("wait_preset", preset_ext_o, 1'b0);
         check_eq("wait_ready", move_ready_o, 1'b0);
         tick();
      end
      lane_end_i = 4'd0;
      if (tmo) m_timeout = 1'b1;
      check_eq("timeout_err", timeout_err_o, m_timeout);
      cell_movable_i = movable;
      spawn_step(1'b0, gi, gp);
      tick();
      check_eq("check_busy", busy_o, 1'b1);
      tick();
      if (movable == 32'd0) begin
         check_eq("over_game_over", game_over_o, 1'b1);
         check_eq("over_ready", move_ready_o, 1'b0);
         check_eq("over_busy", busy_o, 1'b0);
      end else begin
         check_eq("post_game_over", game_over_o, 1'b0);
         check_eq("post_ready", move_ready_o, 1'b1);
         check_eq("post_busy", busy_o, 1'b0);
      end
   endtask

   task automatic bad_move(input logic [3:0] dir);
      move_valid_i = 1'b1;
      move_dir_i   = dir;
      tick();
      move_valid_i = 1'b0;
      move_dir_i   = 4'd0;
      check_eq("bad_seed", ready_seed_o, 4'd0);
      check_eq("bad_busy", busy_o, 1'b0);
      check_eq("bad_ready", move_ready_o, 1'b1);
      tick();
      check_eq("bad_seed2", ready_seed_o, 4'd0);
      check_eq("bad_busy2", busy_o, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] d;
      int         tt[4];
      rst_i          = 1'b1;
      move_valid_i   = 1'b0;
      move_dir_i     = 4'd0;
      lane_end_i     = 4'd0;
      cell_movable_i = 32'hFFFF_FFFF;
      node_score_i   = 16'd0;
      board          = 64'd0;
      snap           = 64'd0;
      m_lfsr         = SEED;
      m_merge        = 16'd0;
      m_timeout      = 1'b0;
      score_en       = 1'b0;

      reset_and_spawn();
      score_en = 1'b1;

      // Lanes finish at +3, +5, +5, +9 cycles after LAUNCH.
      do_move(4'b0001, 2, 4, 4, 8, 1'b0, 1'b1, rand_board(), 32'h0000_0100, 4'd0);

      bad_move(4'b0011);

      // Unchanged board with empty cells: no tile, CHECK still runs.
      board[3:0] = 4'd0;
      do_move(4'b0100, 0, 1, 2, 3, 1'b0, 1'b0, 64'd0, 32'h1, 4'b1111);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            d = 4'($urandom_range(0, 15));
            if ($countones(d) == 1) d = 4'b1010;
            bad_move(d);
         end else begin
            d = 4'(1 << $urandom_range(0, 3));
            for (int l = 0; l < 4; l++)
               tt[l] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 20);
            do_move(d, tt[0], tt[1], tt[2], tt[3], bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) != 0), rand_board(), $urandom | 32'h1,
                    4'($urandom));
         end
      end

      // Lane 3 never reports while the others stay stuck high.
      do_move(4'b1000, 0, 0, 0, NEVER, 1'b1, 1'b1, rand_board(), 32'h8000_0000, 4'd0);
      check_eq("timeout_sticky", timeout_err_o, 1'b1);

      // Reset sampled while ready_seed is active.
      move_valid_i = 1'b1;
      move_dir_i   = 4'b0100;
      tick();
      move_valid_i = 1'b0;
      move_dir_i   = 4'd0;
      check_eq("mid_seed", ready_seed_o, 4'b0100);
      reset_and_spawn();

      // Full board, nothing movable: game over.
      board = 64'h1213_2131_3212_1323;
      do_move(4'b0010, 1, 2, 3, 4, 1'b0, 1'b0, 64'd0, 32'd0, 4'd0);
      move_valid_i = 1'b1;
      move_dir_i   = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         lane_end_i = 4'($urandom);
         tick();
         check_eq("over_ready_hold", move_ready_o, 1'b0);
         check_eq("over_seed_hold", ready_seed_o, 4'd0);
         check_eq("over_busy_hold", busy_o, 1'b0);
         check_eq("over_sticky", game_over_o, 1'b1);
      end
      move_valid_i = 1'b0;
      lane_end_i   = 4'd0;

      score_en     = 1'b0;
      node_score_i = 16'hFFFF;
      repeat (5000) tick();
      check_eq("merge_saturated", merge_count_o, 16'hFFFF);
      node_score_i = 16'd0;
      tick();
      check_eq("merge_sat_hold", merge_count_o, 16'hFFFF);

      board = 64'd0;
      reset_and_spawn();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
